// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: access-size encodings and the access FSM states.
package riscv_pkg;
    localparam int XLEN = 32;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory req/gnt/rvalid handshake; the stage is the master, the memory the slave.
interface mem_stage_if #(parameter int N = 32);
    logic         dmem_req;
    logic         dmem_we;
    logic [N-1:0] dmem_addr;
    logic [N-1:0] dmem_wdata;
    logic [3:0]   dmem_be;
    logic         dmem_gnt;
    logic         dmem_rvalid;
    logic [N-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, load extraction/extension and misalignment detection.
module load_store_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_size,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misaligned
);
    logic [31:0] w_shift;

    always_comb begin
        w_shift      = i_rdata >> {i_addr, 3'b000};
        o_be         = 4'b1111;
        o_wdata      = i_sdata;
        o_ldata      = w_shift;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B, SZ_BU: begin
                o_be    = 4'b0001 << i_addr;
                o_wdata = {4{i_sdata[7:0]}};
                o_ldata = (i_size == SZ_B) ? {{24{w_shift[7]}}, w_shift[7:0]}
                                           : {24'h0, w_shift[7:0]};
            end
            SZ_H, SZ_HU: begin
                o_misaligned = i_addr[0];
                o_be         = 4'b0011 << {i_addr[1], 1'b0};
                o_wdata      = {2{i_sdata[15:0]}};
                o_ldata      = (i_size == SZ_H) ? {{16{w_shift[15]}}, w_shift[15:0]}
                                                : {16'h0, w_shift[15:0]};
            end
            // word and any undefined size behave as a full word
            default: o_misaligned = (i_addr != 2'b00);
        endcase
    end
endmodule

// File: rtl/register_generic.sv
// Enabled pipeline register with synchronous active-high clear; one cycle latency, holds when en=0.
module register_generic #(parameter int N = 32) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: branch resolution, load/store over req/gnt/rvalid, MEM/WB registers (1-cycle latency).
// Stalls upstream while an access is outstanding; a load finished under regEn=0 is parked in DONE.
module mem_stage
    import riscv_pkg::*;
#(parameter int N = XLEN)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         regEn,
    input  logic [N-1:0] ALUres,
    input  logic [N-1:0] Bout,
    input  logic [N-1:0] NPCbranch,
    input  logic [N-1:0] NPC4in,
    input  logic [N-1:0] ImmIN,
    input  logic         zero,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic [2:0]   memSize,
    input  logic         branch,
    input  logic         jump,
    input  logic         jalr,
    output logic         PCsrc,
    output logic [N-1:0] PCtarget,
    output logic         stall,
    output logic         misalign,
    mem_stage_if.master  mem,
    output logic [N-1:0] ALUout,
    output logic [N-1:0] MEMout,
    output logic [N-1:0] NPC4out,
    output logic [N-1:0] ImmOUT
);
    mem_state_t  r_state, w_state_nxt;
    logic        w_access, w_mis, w_valid, w_wb_en;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ldata, r_ldbuf;
    logic [N-1:0] w_mem_nxt;

    assign PCsrc    = jump | (branch & zero);
    assign PCtarget = jalr ? {ALUres[N-1:1], 1'b0} : NPCbranch;

    load_store_align u_align (
        .i_addr       (ALUres[1:0]),
        .i_size       (memSize),
        .i_sdata      (Bout),
        .i_rdata      (mem.dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata),
        .o_misaligned (w_mis)
    );

    assign w_access       = memRead | memWrite;
    assign w_valid        = w_access & ~w_mis;
    assign mem.dmem_we    = memWrite;
    assign mem.dmem_addr  = {ALUres[N-1:2], 2'b00};
    assign mem.dmem_wdata = w_wdata;
    assign mem.dmem_be    = w_be;

    always_comb begin
        w_state_nxt  = r_state;
        mem.dmem_req = 1'b0;
        stall        = 1'b0;
        misalign     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem.dmem_req = w_valid;
                misalign     = w_access & w_mis & regEn;
                if (w_valid) begin
                    stall = ~(mem.dmem_gnt & memWrite);
                    if (!mem.dmem_gnt)  w_state_nxt = ST_REQ;
                    else if (memRead)   w_state_nxt = ST_WAIT;
                end
            end
            ST_REQ: begin
                mem.dmem_req = 1'b1;
                // a store granted here retires now, otherwise IDLE would re-issue it
                stall = ~(mem.dmem_gnt & memWrite);
                if (mem.dmem_gnt) w_state_nxt = memRead ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                stall = ~mem.dmem_rvalid;
                if (mem.dmem_rvalid) w_state_nxt = regEn ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (regEn) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            w_state_nxt  = ST_IDLE;
            mem.dmem_req = 1'b0;
            stall        = 1'b0;
            misalign     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ldbuf <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_WAIT && mem.dmem_rvalid) r_ldbuf <= w_ldata;
        end
    end

    always_comb begin
        w_mem_nxt = '0;
        if (r_state == ST_WAIT && mem.dmem_rvalid) w_mem_nxt = w_ldata;
        else if (r_state == ST_DONE)               w_mem_nxt = r_ldbuf;
    end

    assign w_wb_en = regEn & ~stall;

    register_generic #(.N(N)) u_alu_reg  (.clk(clk), .rst(rst), .en(w_wb_en), .d(ALUres),    .q(ALUout));
    register_generic #(.N(N)) u_mem_reg  (.clk(clk), .rst(rst), .en(w_wb_en), .d(w_mem_nxt), .q(MEMout));
    register_generic #(.N(N)) u_npc4_reg (.clk(clk), .rst(rst), .en(w_wb_en), .d(NPC4in),    .q(NPC4out));
    register_generic #(.N(N)) u_imm_reg  (.clk(clk), .rst(rst), .en(w_wb_en), .d(ImmIN),     .q(ImmOUT));
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a cycle-stepped memory model answers requests with programmable delays.
module tb_mem_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, regEn, zero, memRead, memWrite, branch, jump, jalr;
    logic [2:0]  memSize;
    logic [31:0] ALUres, Bout, NPCbranch, NPC4in, ImmIN;
    logic        PCsrc, stall, misalign;
    logic [31:0] PCtarget, ALUout, MEMout, NPC4out, ImmOUT;

    mem_stage_if #(.N(32)) dmem_if ();

    mem_stage #(.N(32)) dut (
        .clk(clk), .rst(rst), .regEn(regEn),
        .ALUres(ALUres), .Bout(Bout), .NPCbranch(NPCbranch), .NPC4in(NPC4in), .ImmIN(ImmIN),
        .zero(zero), .memRead(memRead), .memWrite(memWrite), .memSize(memSize),
        .branch(branch), .jump(jump), .jalr(jalr),
        .PCsrc(PCsrc), .PCtarget(PCtarget), .stall(stall), .misalign(misalign),
        .mem(dmem_if.master),
        .ALUout(ALUout), .MEMout(MEMout), .NPC4out(NPC4out), .ImmOUT(ImmOUT)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] npc4;
        logic [31:0] imm;
    } wb_t;

    wb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One instruction through the stage; memory grants after gdly request cycles and
    // returns data rdly cycles after the cycle following the grant.
    task automatic do_op(input string nm, input logic rd, input logic wr, input logic [2:0] sz,
                         input logic [31:0] addr, input logic [31:0] bout, input logic [31:0] rdata,
                         input int gdly, input int rdly, input int hold, input int exp_stall,
                         input logic exp_mis, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_mem);
        int          stall_n = 0, mis_n = 0, gnt_n = 0, req_after = 0, wcnt = 0, rcnt = 0, post = 0;
        logic        granted = 1'b0, rv_seen = 1'b0, done = 1'b0, seen_req = 1'b0;
        logic        req_moved = 1'b0, mem_moved = 1'b0, g_now, r_now, q_now, rv_before;
        logic [31:0] a0 = '0, wd0 = '0, held_mem;
        logic [3:0]  be0 = '0;
        logic        we0 = 1'b0;
        wb_t         exp_wb;
        sb_q.push_back({addr, exp_mem, addr + 32'd4, addr ^ 32'h5A5A});
        held_mem = MEMout;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            memRead = rd; memWrite = wr; memSize = sz; ALUres = addr; Bout = bout;
            NPC4in = addr + 32'd4; ImmIN = addr ^ 32'h5A5A;
            regEn = (hold == 0) || (rv_seen && post >= hold);
            dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = rdata;
            #1;
            if (dmem_if.dmem_req && !granted && !rv_seen && wcnt >= gdly) dmem_if.dmem_gnt = 1'b1;
            if (granted && rcnt >= rdly) dmem_if.dmem_rvalid = 1'b1;
            #1;
            if (dmem_if.dmem_req) begin
                if (granted || rv_seen) req_after++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    a0 = dmem_if.dmem_addr; be0 = dmem_if.dmem_be;
                    wd0 = dmem_if.dmem_wdata; we0 = dmem_if.dmem_we;
                end else if (dmem_if.dmem_addr !== a0 || dmem_if.dmem_be !== be0 ||
                             dmem_if.dmem_wdata !== wd0) begin
                    req_moved = 1'b1;
                end
            end
            stall_n += int'(stall);
            mis_n   += int'(misalign);
            if (MEMout !== held_mem) mem_moved = 1'b1;
            if (regEn && !stall) done = 1'b1;
            q_now = dmem_if.dmem_req;
            g_now = dmem_if.dmem_req & dmem_if.dmem_gnt;
            r_now = dmem_if.dmem_rvalid;
            rv_before = rv_seen;
            @(posedge clk);
            if (g_now) begin gnt_n++; granted = rd; end
            else if (q_now) wcnt++;
            if (granted && !g_now && !r_now) rcnt++;
            if (r_now) begin rv_seen = 1'b1; granted = 1'b0; end
            if (rv_before) post++;
        end
        #1;
        if (!done) check_eq({nm, "_timeout"}, 32'd0, 32'd1);
        check_eq({nm, "_stall_cycles"}, stall_n, exp_stall);
        check_eq({nm, "_misalign_pulses"}, mis_n, {31'd0, exp_mis});
        check_eq({nm, "_grants"}, gnt_n, exp_mis ? 32'd0 : 32'd1);
        check_eq({nm, "_rerequest"}, req_after, 32'd0);
        check_eq({nm, "_req_stable"}, {31'd0, req_moved}, 32'd0);
        check_eq({nm, "_memout_held"}, {31'd0, mem_moved}, 32'd0);
        if (!exp_mis) begin
            check_eq({nm, "_addr"}, a0, {addr[31:2], 2'b00});
            check_eq({nm, "_we"}, {31'd0, we0}, {31'd0, wr});
            if (wr) begin
                check_eq({nm, "_be"}, {28'd0, be0}, {28'd0, exp_be});
                check_eq({nm, "_wdata"}, wd0, exp_wdata);
            end
        end
        exp_wb = sb_q.pop_front();
        check_eq({nm, "_ALUout"},  ALUout,  exp_wb.alu);
        check_eq({nm, "_MEMout"},  MEMout,  exp_wb.mem);
        check_eq({nm, "_NPC4out"}, NPC4out, exp_wb.npc4);
        check_eq({nm, "_ImmOUT"},  ImmOUT,  exp_wb.imm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; regEn = 1'b1; zero = 1'b0; branch = 1'b0; jump = 1'b0; jalr = 1'b0;
        memRead = 1'b1; memWrite = 1'b0; memSize = SZ_W; ALUres = 32'h101;
        Bout = '0; NPCbranch = '0; NPC4in = 32'h1111; ImmIN = 32'h2222;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = '0;
        @(negedge clk);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
        ALUres = 32'h100;
        #1;
        check_eq("rst_req", {31'd0, dmem_if.dmem_req}, 32'd0);
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check_eq("rst_ALUout", ALUout, 32'd0);
        check_eq("rst_MEMout", MEMout, 32'd0);
        check_eq("rst_NPC4out", NPC4out, 32'd0);
        check_eq("rst_ImmOUT", ImmOUT, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //    name     rd    wr    size   addr      bout          rdata         g  r  h  st mis  be       wdata         memout
        do_op("sw",   1'b0, 1'b1, SZ_W,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
        do_op("lb",   1'b1, 1'b0, SZ_B,  32'h103, 32'h0,        32'h80FFFF00, 0, 0, 0, 1, 1'b0, 4'b0,    32'h0,        32'hFFFFFF80);
        do_op("lbu",  1'b1, 1'b0, SZ_BU, 32'h103, 32'h0,        32'h80FFFF00, 0, 0, 0, 1, 1'b0, 4'b0,    32'h0,        32'h00000080);
        do_op("lh",   1'b1, 1'b0, SZ_H,  32'h102, 32'h0,        32'h9ABC1234, 3, 1, 0, 5, 1'b0, 4'b0,    32'h0,        32'hFFFF9ABC);
        do_op("lw_mis", 1'b1, 1'b0, SZ_W, 32'h101, 32'h0,       32'h12345678, 0, 0, 0, 0, 1'b1, 4'b0,    32'h0,        32'h0);
        do_op("sb",   1'b0, 1'b1, SZ_B,  32'h102, 32'h11223344, 32'h0,        0, 0, 0, 0, 1'b0, 4'b0100, 32'h44444444, 32'h0);
        do_op("lhu",  1'b1, 1'b0, SZ_HU, 32'h100, 32'h0,        32'h1234F00D, 1, 2, 0, 4, 1'b0, 4'b0,    32'h0,        32'h0000F00D);
        do_op("sh_mis", 1'b0, 1'b1, SZ_H, 32'h203, 32'h5555AAAA, 32'h0,       0, 0, 0, 0, 1'b1, 4'b0,    32'h0,        32'h0);
        do_op("sh",   1'b0, 1'b1, SZ_H,  32'h202, 32'h1234ABCD, 32'h0,        0, 0, 0, 0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0);
        do_op("lw_hold", 1'b1, 1'b0, SZ_W, 32'h104, 32'h0,      32'hCAFEF00D, 0, 0, 2, 1, 1'b0, 4'b0,    32'h0,        32'hCAFEF00D);

        @(negedge clk);
        memRead = 1'b0; memWrite = 1'b0; regEn = 1'b0;
        branch = 1'b1; zero = 1'b1; NPCbranch = 32'h40; ALUres = 32'h81;
        #1;
        check_eq("beq_taken_PCsrc", {31'd0, PCsrc}, 32'd1);
        check_eq("beq_taken_PCtarget", PCtarget, 32'h40);
        zero = 1'b0;
        #1;
        check_eq("beq_not_taken_PCsrc", {31'd0, PCsrc}, 32'd0);
        branch = 1'b0; jump = 1'b1; jalr = 1'b1;
        #1;
        check_eq("jalr_PCsrc", {31'd0, PCsrc}, 32'd1);
        check_eq("jalr_PCtarget", PCtarget, 32'h80);
        jump = 1'b0; jalr = 1'b0;

        // reset lands while a load is waiting for its data
        @(negedge clk);
        regEn = 1'b1; memRead = 1'b1; memSize = SZ_W; ALUres = 32'h300;
        #1;
        dmem_if.dmem_gnt = 1'b1;
        #1;
        check_eq("rstwait_req", {31'd0, dmem_if.dmem_req}, 32'd1);
        @(negedge clk);
        dmem_if.dmem_gnt = 1'b0; rst = 1'b1;
        #1;
        check_eq("rstwait_stall", {31'd0, stall}, 32'd0);
        check_eq("rstwait_req_low", {31'd0, dmem_if.dmem_req}, 32'd0);
        @(posedge clk); #1;
        check_eq("rstwait_ALUout", ALUout, 32'd0);
        check_eq("rstwait_MEMout", MEMout, 32'd0);
        check_eq("rstwait_NPC4out", NPC4out, 32'd0);
        check_eq("rstwait_ImmOUT", ImmOUT, 32'd0);
        @(negedge clk);
        rst = 1'b0; memRead = 1'b0; ALUres = 32'h55;
        dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hFFFFFFFF;
        #1;
        check_eq("late_rvalid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        check_eq("late_rvalid_MEMout", MEMout, 32'd0);
        check_eq("late_rvalid_ALUout", ALUout, 32'h55);
        @(negedge clk);
        dmem_if.dmem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
